// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared register offsets, bit indices and offset decode for the timer compare unit
package timer_pkg;

  localparam logic [3:0] TMR_CMP_LO = 4'h0;
  localparam logic [3:0] TMR_CMP_HI = 4'h4;
  localparam logic [3:0] TMR_CTRL   = 4'h8;
  localparam logic [3:0] TMR_STATUS = 4'hC;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int STAT_PEND = 0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_CTRL,
    SEL_STATUS
  } reg_sel_e;

  // Any offset outside the map selects nothing: reads give 0, writes are dropped.
  function automatic reg_sel_e decode_ofs(input logic [3:0] ofs);
    reg_sel_e sel;
    case (ofs)
      TMR_CMP_LO: sel = SEL_CMP_LO;
      TMR_CMP_HI: sel = SEL_CMP_HI;
      TMR_CTRL:   sel = SEL_CTRL;
      TMR_STATUS: sel = SEL_STATUS;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/timer_cmp_if.sv
// rtl/timer_cmp_if.sv - 32-bit MMIO slave bus shared with the timer
interface timer_cmp_if;

  logic        ren;
  logic        wen;
  logic [3:0]  addr_ofs;
  logic [31:0] wdata;
  logic [31:0] data_o;

  modport master (
    output ren,
    output wen,
    output addr_ofs,
    output wdata,
    input  data_o
  );

  modport slave (
    input  ren,
    input  wen,
    input  addr_ofs,
    input  wdata,
    output data_o
  );

endinterface

// File: rtl/cmp64_pipe.sv
// rtl/cmp64_pipe.sv - registered unsigned 64-bit a >= b, one cycle latency
module cmp64_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic        ge_o
);

  logic hi_gt;
  logic hi_eq;
  logic lo_ge;
  logic ge_d;
  logic ge_q;

  // Compare the halves separately so each carry chain is only 32 bits long.
  always_comb begin
    hi_gt = (a_i[63:32] >  b_i[63:32]);
    hi_eq = (a_i[63:32] == b_i[63:32]);
    lo_ge = (a_i[31:0]  >= b_i[31:0]);
    ge_d  = hi_gt | (hi_eq & lo_ge);
  end

  // Result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ge_q <= 1'b0;
    end else begin
      ge_q <= ge_d;
    end
  end

  assign ge_o = ge_q;

endmodule

// File: rtl/timer_cmp.sv
// rtl/timer_cmp.sv - 64-bit compare/interrupt unit with shadowed low half and sticky pending
module timer_cmp
  import timer_pkg::*;
#(
  parameter logic [63:0] RST_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] time_i,
  timer_cmp_if.slave  bus,
  output logic        irq_o
);

  logic [63:0] cmp_q, cmp_d;
  logic [31:0] lo_shadow_q, lo_shadow_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        pending_q, pending_d;
  logic        irq_q, irq_d;
  logic [31:0] data_q, data_d;

  logic        match_q;
  reg_sel_e    sel;
  logic [31:0] rdata;
  logic        w1c_pend;

  // Match stage sees only the committed compare value, never the shadow.
  cmp64_pipe u_cmp (
    .clk   (clk),
    .rst_n (rst_n),
    .a_i   (time_i),
    .b_i   (cmp_q),
    .ge_o  (match_q)
  );

  // Read mux from current state, so a same-cycle write is not visible yet.
  always_comb begin
    sel   = decode_ofs(bus.addr_ofs);
    rdata = '0;
    case (sel)
      SEL_CMP_LO: rdata = cmp_q[31:0];
      SEL_CMP_HI: rdata = cmp_q[63:32];
      SEL_CTRL: begin
        rdata[CTRL_EN] = en_q;
        rdata[CTRL_IE] = ie_q;
      end
      SEL_STATUS: rdata[STAT_PEND] = pending_q;
      default: rdata = '0;
    endcase
    data_d = bus.ren ? rdata : '0;
  end

  // Register writes, pending set/clear (set wins) and interrupt level.
  always_comb begin
    cmp_d       = cmp_q;
    lo_shadow_d = lo_shadow_q;
    en_d        = en_q;
    ie_d        = ie_q;
    w1c_pend    = 1'b0;
    if (bus.wen) begin
      case (sel)
        SEL_CMP_LO: lo_shadow_d = bus.wdata;
        SEL_CMP_HI: cmp_d = {bus.wdata, lo_shadow_q};
        SEL_CTRL: begin
          en_d = bus.wdata[CTRL_EN];
          ie_d = bus.wdata[CTRL_IE];
        end
        SEL_STATUS: w1c_pend = bus.wdata[STAT_PEND];
        default: ;
      endcase
    end
    if (en_q && match_q) begin
      pending_d = 1'b1;
    end else if (w1c_pend) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    irq_d = pending_q & ie_q;
  end

  // State registers; reset also clears a half-written shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q       <= RST_CMP;
      lo_shadow_q <= '0;
      en_q        <= 1'b0;
      ie_q        <= 1'b0;
      pending_q   <= 1'b0;
      irq_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      cmp_q       <= cmp_d;
      lo_shadow_q <= lo_shadow_d;
      en_q        <= en_d;
      ie_q        <= ie_d;
      pending_q   <= pending_d;
      irq_q       <= irq_d;
      data_q      <= data_d;
    end
  end

  assign bus.data_o = data_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_timer_cmp.sv
// tb/tb_timer_cmp.sv - randomized and directed self-checking bench for timer_cmp
module tb_timer_cmp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] time_r = '0;
  logic        irq_o;
  logic        ramp = 1'b0;

  timer_cmp_if bus_if ();

  timer_cmp dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .time_i (time_r),
    .bus    (bus_if),
    .irq_o  (irq_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus the two visible delays.
  logic [63:0] m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
  logic [31:0] m_shadow = '0;
  logic        m_en = 1'b0, m_ie = 1'b0, m_pend = 1'b0;
  logic        m_reached = 1'b0;
  logic        m_irq = 1'b0;
  logic [31:0] m_data = '0;
  logic [63:0] n_cmp;
  logic [31:0] n_shadow, n_data;
  logic        n_en, n_ie, n_pend, n_reached, n_irq;

  function automatic logic [31:0] m_read(input logic [3:0] o);
    case (o)
      4'h0: return m_cmp[31:0];
      4'h4: return m_cmp[63:32];
      4'h8: return {30'b0, m_ie, m_en};
      4'hC: return {31'b0, m_pend};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_shadow = '0;
      m_en = 0; m_ie = 0; m_pend = 0; m_reached = 0; m_irq = 0; m_data = '0;
    end else begin
      n_data    = bus_if.ren ? m_read(bus_if.addr_ofs) : 32'h0;
      n_reached = (time_r >= m_cmp);
      n_irq     = m_pend && m_ie;
      n_cmp = m_cmp; n_shadow = m_shadow; n_en = m_en; n_ie = m_ie; n_pend = m_pend;
      if (bus_if.wen && bus_if.addr_ofs == 4'hC && bus_if.wdata[0]) n_pend = 1'b0;
      if (m_en && m_reached) n_pend = 1'b1;
      if (bus_if.wen) begin
        if (bus_if.addr_ofs == 4'h0) n_shadow = bus_if.wdata;
        if (bus_if.addr_ofs == 4'h4) n_cmp = {bus_if.wdata, m_shadow};
        if (bus_if.addr_ofs == 4'h8) begin n_en = bus_if.wdata[0]; n_ie = bus_if.wdata[1]; end
      end
      m_cmp = n_cmp; m_shadow = n_shadow; m_en = n_en; m_ie = n_ie; m_pend = n_pend;
      m_reached = n_reached; m_irq = n_irq; m_data = n_data;
    end
  end

  // Every-cycle comparison of both outputs against the model.
  always @(negedge clk) begin
    chk("model_data_o", {32'h0, bus_if.data_o}, {32'h0, m_data});
    chk("model_irq_o", {63'h0, irq_o}, {63'h0, m_irq});
  end

  task automatic cyc();
    @(negedge clk);
    if (ramp) time_r = time_r + 64'd1;
  endtask

  task automatic wr(input logic [3:0] o, input logic [31:0] d);
    bus_if.wen = 1'b1; bus_if.addr_ofs = o; bus_if.wdata = d;
    cyc();
    bus_if.wen = 1'b0;
  endtask

  task automatic rd(input logic [3:0] o, output logic [31:0] d);
    bus_if.ren = 1'b1; bus_if.addr_ofs = o;
    cyc();
    d = bus_if.data_o;
    bus_if.ren = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_data_o", {32'h0, bus_if.data_o}, 64'h0);
      chk("rst_irq_o", {63'h0, irq_o}, 64'h0);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [31:0] d;
  logic [63:0] hit_time;
  logic [63:0] prev;
  logic        seen;

  initial begin
    bus_if.ren = 0; bus_if.wen = 0; bus_if.addr_ofs = '0; bus_if.wdata = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset values through the bus
    rd(4'h0, d); chk("rst_cmp_lo", {32'h0, d}, 64'hFFFF_FFFF);
    rd(4'h4, d); chk("rst_cmp_hi", {32'h0, d}, 64'hFFFF_FFFF);
    rd(4'h8, d); chk("rst_ctrl", {32'h0, d}, 64'h0);
    rd(4'hC, d); chk("rst_status", {32'h0, d}, 64'h0);
    chk("rst_irq", {63'h0, irq_o}, 64'h0);

    // Commit and fire: irq on the edge that samples time 0x100 + 2
    time_r = 64'hF0; ramp = 1'b1;
    wr(4'h0, 32'h100); wr(4'h4, 32'h0); wr(4'h8, 32'h3);
    seen = 1'b0; hit_time = '0;
    for (int i = 0; i < 64 && !seen; i++) begin
      prev = time_r;
      cyc();
      if (irq_o) begin seen = 1'b1; hit_time = prev; end
    end
    chk("fire_seen", {63'h0, seen}, 64'h1);
    chk("fire_time", hit_time, 64'h102);
    rd(4'hC, d); chk("fire_status", {32'h0, d}, 64'h1);

    // Set-wins race, then drop once the match is gone
    wr(4'hC, 32'h1); chk("race_irq", {63'h0, irq_o}, 64'h1);
    rd(4'hC, d); chk("race_status", {32'h0, d}, 64'h1);
    wr(4'h4, 32'hFFFF_FFFF);
    cyc();
    wr(4'hC, 32'h1); chk("clr_irq_hold", {63'h0, irq_o}, 64'h1);
    cyc(); chk("clr_irq_drop", {63'h0, irq_o}, 64'h0);
    rd(4'hC, d); chk("clr_status", {32'h0, d}, 64'h0);

    // Atomicity: shadow write alone must not change matching
    do_reset();
    ramp = 1'b0; time_r = 64'h20;
    wr(4'h8, 32'h3); wr(4'h0, 32'h10);
    repeat (20) cyc();
    chk("atom_irq", {63'h0, irq_o}, 64'h0);
    rd(4'hC, d); chk("atom_status", {32'h0, d}, 64'h0);
    rd(4'h0, d); chk("atom_cmp_lo", {32'h0, d}, 64'hFFFF_FFFF);
    wr(4'h4, 32'h0);
    cyc(); chk("atom_e1", {63'h0, irq_o}, 64'h0);
    cyc(); chk("atom_e2", {63'h0, irq_o}, 64'h0);
    cyc(); chk("atom_e3", {63'h0, irq_o}, 64'h1);

    // Wrap and interrupt gating
    do_reset();
    ramp = 1'b1; time_r = 64'hFFFF_FFFF_FFFF_FFE0;
    wr(4'h0, 32'hFFFF_FFF0); wr(4'h4, 32'hFFFF_FFFF); wr(4'h8, 32'h1);
    repeat (24) cyc();
    rd(4'hC, d); chk("wrap_pend", {32'h0, d}, 64'h1);
    chk("wrap_irq_gated", {63'h0, irq_o}, 64'h0);
    repeat (20) cyc();
    chk("wrap_crossed", {63'h0, time_r < 64'h100}, 64'h1);
    rd(4'hC, d); chk("wrap_pend_kept", {32'h0, d}, 64'h1);
    chk("wrap_irq_still0", {63'h0, irq_o}, 64'h0);
    wr(4'h8, 32'h3); chk("ie_edge0", {63'h0, irq_o}, 64'h0);
    cyc(); chk("ie_edge1", {63'h0, irq_o}, 64'h1);

    // Simultaneous read and write of CTRL returns the old value
    bus_if.ren = 1'b1; bus_if.wen = 1'b1; bus_if.addr_ofs = 4'h8; bus_if.wdata = 32'h0;
    cyc();
    bus_if.ren = 1'b0; bus_if.wen = 1'b0;
    chk("rw_old", {32'h0, bus_if.data_o}, 64'h3);
    rd(4'h8, d); chk("rw_new", {32'h0, d}, 64'h0);
    wr(4'h2, 32'hFFFF_FFFF); rd(4'h2, d); chk("undef_ofs", {32'h0, d}, 64'h0);

    // Reset between the two halves clears the shadow
    wr(4'h0, 32'h1234_5678);
    do_reset();
    wr(4'h4, 32'h0);
    rd(4'h0, d); chk("shadow_lo", {32'h0, d}, 64'h0);
    rd(4'h4, d); chk("shadow_hi", {32'h0, d}, 64'h0);

    // Randomized traffic against the model
    ramp = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [3:0] o;
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 4))
        0: o = 4'h0;
        1: o = 4'h4;
        2: o = 4'h8;
        3: o = 4'hC;
        default: o = 4'($urandom);
      endcase
      bus_if.addr_ofs = o;
      bus_if.ren = ($urandom_range(0, 2) == 0);
      bus_if.wen = ($urandom_range(0, 3) == 0);
      if (o == 4'h0) bus_if.wdata = time_r[31:0] + 32'($urandom_range(0, 40));
      else if (o == 4'h4) bus_if.wdata = time_r[63:32] + 32'($urandom_range(0, 1));
      else bus_if.wdata = $urandom;
      if (r < 2) time_r = {32'hFFFF_FFFF, 32'($urandom_range(32'hFFFF_FF00, 32'hFFFF_FFFF))};
      else if (r == 2) time_r = {$urandom, $urandom};
      if (r == 99 && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        if (ramp) time_r = time_r + 64'd1;
      end else begin
        cyc();
      end
      bus_if.ren = 1'b0;
      bus_if.wen = 1'b0;
    end
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_cmp.md
# timer_cmp

Compare/interrupt unit downstream of the 64-bit free-running timer. It consumes the timer's live 64-bit count, holds a software-programmed 64-bit compare value written through the same 32-bit MMIO slave protocol as the timer, and raises a sticky, level interrupt toward the core once the count reaches the compare value. A shadowed low half lets software update the compare value atomically.

## Interface
- `RST_CMP`, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of the committed compare register, so no match occurs after reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `time_i`  in  64  live count from the timer; increments by one per cycle, may wrap.
- `ren`  in  1  read strobe, one cycle per access.
- `wen`  in  1  write strobe, one cycle per access.
- `addr_ofs`  in  4  byte offset of the register: 0x0, 0x4, 0x8 or 0xC.
- `wdata`  in  32  write data.
- `data_o`  out  32  read data, registered.
- `irq_o`  out  1  interrupt request, registered level.

## Operation
- Register map:
  - 0x0 CMP_LO: write goes to the 32-bit shadow `lo_shadow`; read returns committed `cmp[31:0]`.
  - 0x4 CMP_HI: write commits `cmp <= {wdata, lo_shadow}` in one edge; read returns `cmp[63:32]`.
  - 0x8 CTRL: bit0 `en` (compare enable), bit1 `ie` (interrupt enable); bits 31:2 read 0, writes ignored.
  - 0xC STATUS: bit0 `pending`; writing 1 to bit0 clears it, writing 0 has no effect; other bits read 0.
  - Undefined offsets read 0 and ignore writes.
- Match stage: `match_q <= (time_i >= cmp)` every cycle, unsigned 64-bit compare against the committed `cmp` value.
- Pending:
  - Set when `en & match_q`.
  - Cleared by a W1C on STATUS.
  - If set and clear occur on the same edge, set wins.
- Interrupt: `irq_o <= pending & ie`. It stays asserted while pending is set. Software clears the interrupt by committing a new compare value and then clearing STATUS.
- Write to CMP_LO alone never changes `cmp` and never affects matching.
- Wrap-around: when `time_i` wraps from all-ones to 0, `match_q` drops unless `cmp` is 0. A pending bit that is already set stays set.
- Clearing `en` stops new sets but does not clear pending.
- `ren` and `wen` asserted together at the same offset: the read returns the value before the write; the write takes effect.

## Timing
- Reset values:
  - `data_o` = 0, `irq_o` = 0.
  - `cmp` = RST_CMP, `lo_shadow` = 0.
  - `en` = `ie` = 0, `pending` = 0, `match_q` = 0.
- Read latency: 1 cycle. `data_o` is valid on the cycle after `ren`. `data_o` = 0 in any cycle following `ren` = 0.
- Write: takes effect at the edge where `wen` is sampled high.
- `time_i` to `irq_o`, counted from the first edge at which `time_i >= cmp` is sampled, with `en` = `ie` = 1:
  - that edge sets `match_q`;
  - the next edge sets `pending`;
  - the edge after that sets `irq_o`;
  - total latency 3 edges.
- CMP_HI commit to `match_q` reflecting the new `cmp`: 1 edge.
- W1C on STATUS with the match condition gone: `pending` falls at the write edge, `irq_o` falls one edge later.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously), including a half-written shadow.

## Structure
- Shared package `timer_pkg`:
  - offset constants TMR_CMP_LO = 4'h0, TMR_CMP_HI = 4'h4, TMR_CTRL = 4'h8, TMR_STATUS = 4'hC;
  - CTRL bit indices CTRL_EN = 0, CTRL_IE = 1;
  - STATUS bit index STAT_PEND = 0.
- The timer's own offsets (0x0, 0x4) stay local to the timer. The top-level decoder routes by base address.
- One natural sub-module: `cmp64_pipe`, the registered 64-bit unsigned `>=` stage. It can be split into two 32-bit halves internally if timing requires, provided the end-to-end latency stays 1 cycle.

## Test plan
- Reset, then read each offset:
  - 0x0 returns 0xFFFFFFFF and 0x4 returns 0xFFFFFFFF;
  - 0x8 and 0xC return 0;
  - `irq_o` = 0.
- Commit and fire: write CMP_LO = 0x00000100, CMP_HI = 0, CTRL = 0x3, with `time_i` ramping from 0xF0.
  - `irq_o` rises 3 edges after `time_i` reaches 0x100;
  - STATUS reads 0x1.
- Atomicity: write CMP_LO = 0x10 while `cmp` = 0xFFFF_FFFF_FFFF_FFFF and `time_i` = 0x20, then hold 20 cycles.
  - no pending, no irq;
  - write CMP_HI = 0: pending sets 2 edges later.
- Set-wins race: with the match still true and `en` = 1, W1C STATUS.
  - pending stays 1 and `irq_o` stays 1;
  - write CMP_HI = 0xFFFFFFFF, then W1C: `irq_o` drops 1 edge after the W1C.
- Wrap and gating, with `cmp` = 0xFFFF_FFFF_FFFF_FFF0, `en` = 1, `ie` = 0, `time_i` crossing the wrap:
  - pending sets;
  - `irq_o` stays 0 until `ie` is written to 1, then rises 1 edge later;
  - after the wrap, pending remains set.
- Async reset asserted between the CMP_LO and CMP_HI writes:
  - after release, a CMP_HI = 0 write commits `cmp` = 0, because the shadow was cleared;
  - `data_o` = 0 throughout reset.
